// File: rtl/custom_seq_if.sv
// -----------------------------------------------------------------------------
// custom_seq_if
// Bundles the command side (core decode -> sequencer) and the data-memory
// port (sequencer -> memory) of the custom-0 sequencer.
//   slave  : the sequencer itself (accepts commands, drives the memory port)
//   master : the environment (core decode + data memory)
// Signals:
//   start/op/base_a/base_b/base_c : command issue
//   busy/done/result              : stall, completion pulse, rd value
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : single-outstanding
//                                   req/ack memory handshake
// -----------------------------------------------------------------------------
interface custom_seq_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] base_a;
  logic [AW-1:0] base_b;
  logic [AW-1:0] base_c;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  start, op, base_a, base_b, base_c, mem_rdata, mem_ack,
    output busy, done, result, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output start, op, base_a, base_b, base_c, mem_rdata, mem_ack,
    input  busy, done, result, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/custom_seq.sv
// -----------------------------------------------------------------------------
// custom_seq
// Multi-cycle sequencer for custom-0 instructions over an NxN int32 matrix
// held in data memory:
//   op 00 : matrix multiply C = A * B (products/sums wrap mod 2^DW),
//           result = N*N
//   op 01 : ReLU Y = max(X, 0) elementwise (signed), result = number of
//           negative elements clamped
//   op 1x : illegal, completes immediately with result = 0, no memory access
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; abandons any operation in flight
//   bus  : custom_seq_if.slave (command issue, busy/done/result, memory port)
// Memory outputs are decoded from the registered state and index registers,
// so they are stable for as long as a request waits for mem_ack, and they
// fall immediately when rst forces the state back to IDLE.
// -----------------------------------------------------------------------------
module custom_seq #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst,
  custom_seq_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;          // row/column/k index
  localparam int EW = (N * N > 1) ? $clog2(N * N) : 1;  // flat element index
  localparam int CW = $clog2(N * N + 1);                // clamp count 0..N*N

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR_C,
    S_RD_X,
    S_WR_Y,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [1:0]    r_op;
  logic [AW-1:0] r_base_a;
  logic [AW-1:0] r_base_b;
  logic [AW-1:0] r_base_c;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_a;      // A element (matmul) or X element (ReLU)
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;
  logic [EW-1:0] r_e;
  logic [CW-1:0] r_clamp;

  logic          w_k_last;
  logic          w_j_last;
  logic          w_i_last;
  logic          w_e_last;
  logic [DW-1:0] w_prod;
  logic [AW-1:0] w_idx_ik;
  logic [AW-1:0] w_idx_kj;
  logic [AW-1:0] w_idx_ij;
  logic [AW-1:0] w_idx_e;

  logic          w_mem_req;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [DW-1:0] w_result;

  assign w_k_last = (r_k == IW'(N - 1));
  assign w_j_last = (r_j == IW'(N - 1));
  assign w_i_last = (r_i == IW'(N - 1));
  assign w_e_last = (r_e == EW'(N * N - 1));

  // Low DW bits of the product; identical for signed and unsigned operands.
  assign w_prod   = r_a * bus.mem_rdata;

  // Element indices (row-major); scaled by 4 bytes and wrapped mod 2^AW below.
  assign w_idx_ik = AW'(r_i) * AW'(N) + AW'(r_k);
  assign w_idx_kj = AW'(r_k) * AW'(N) + AW'(r_j);
  assign w_idx_ij = AW'(r_i) * AW'(N) + AW'(r_j);
  assign w_idx_e  = AW'(r_e);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. mem_ack only matters in the states that hold mem_req,
  // so an ack with no request outstanding is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns w_next -- no latch inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b00:   w_next = S_RD_A;
            2'b01:   w_next = S_RD_X;
            default: w_next = S_DONE;
          endcase
        end
      end
      S_RD_A: if (bus.mem_ack) w_next = S_RD_B;
      S_RD_B: if (bus.mem_ack) w_next = w_k_last ? S_WR_C : S_RD_A;
      S_WR_C: if (bus.mem_ack) w_next = (w_i_last && w_j_last) ? S_DONE : S_RD_A;
      S_RD_X: if (bus.mem_ack) w_next = S_WR_Y;
      S_WR_Y: if (bus.mem_ack) w_next = w_e_last ? S_DONE : S_RD_X;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_result    = '0;
    case (r_state)
      S_RD_A: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_base_a + (w_idx_ik << 2);
      end
      S_RD_B: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_base_b + (w_idx_kj << 2);
      end
      S_WR_C: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_base_c + (w_idx_ij << 2);
        w_mem_wdata = r_acc;
      end
      S_RD_X: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_base_a + (w_idx_e << 2);
      end
      S_WR_Y: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_base_c + (w_idx_e << 2);
        w_mem_wdata = r_a[DW-1] ? '0 : r_a;
      end
      S_DONE: begin
        case (r_op)
          2'b00:   w_result = DW'(N * N);
          2'b01:   w_result = DW'(r_clamp);
          default: w_result = '0;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = w_result;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  // ---------------------------------------------------------------------------
  // Datapath: command capture, accumulator and loop indices
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_e      <= '0;
      r_clamp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.op;
            r_base_a <= bus.base_a;
            r_base_b <= bus.base_b;
            r_base_c <= bus.base_c;
            r_acc    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_e      <= '0;
            r_clamp  <= '0;
          end
        end
        S_RD_A, S_RD_X: begin
          if (bus.mem_ack) r_a <= bus.mem_rdata;
        end
        S_RD_B: begin
          if (bus.mem_ack) begin
            r_acc <= r_acc + w_prod;
            if (!w_k_last) r_k <= r_k + IW'(1);
          end
        end
        S_WR_C: begin
          if (bus.mem_ack) begin
            r_acc <= '0;
            r_k   <= '0;
            if (w_j_last) begin
              r_j <= '0;
              if (!w_i_last) r_i <= r_i + IW'(1);
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        S_WR_Y: begin
          if (bus.mem_ack) begin
            if (r_a[DW-1]) r_clamp <= r_clamp + CW'(1);
            if (!w_e_last) r_e <= r_e + EW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_seq.sv
// -----------------------------------------------------------------------------
// tb_custom_seq
// Scoreboard bench for custom_seq (N=2). Each issued operation pushes its
// expected memory transactions and its expected result/busy length, derived
// from the matrix-multiply and ReLU definitions. A memory responder with
// optional random wait states serves the DUT, compares every completed
// transaction against the queue head, and a monitor compares result and
// busy length whenever done is seen.
// -----------------------------------------------------------------------------
module tb_custom_seq;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  custom_seq_if #(.AW(AW), .DW(DW)) bus ();

  custom_seq #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    logic [DW-1:0] result;
    int            base;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder + done monitor (decisions on the falling edge)
  // ---------------------------------------------------------------------------
  bit   pending   = 1'b0;
  int   waits_left;
  int   max_wait  = 0;
  int   op_waits  = 0;
  int   busy_cnt  = 0;
  int   done_cnt  = 0;
  acc_t snap;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.mem_req) begin
        if (!pending) begin
          pending    = 1'b1;
          snap       = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
          waits_left = $urandom_range(max_wait, 0);
        end else begin
          check("req_stable", {31'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                              {31'd0, snap.we, snap.addr, snap.data});
        end
        if (waits_left == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_rd(bus.mem_addr);
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
          waits_left--;
          op_waits++;
        end
      end else begin
        // Stray acks with no request must be ignored by the DUT.
        bus.mem_ack   = 1'($urandom_range(1, 0));
        bus.mem_rdata = $urandom;
      end
      if (bus.done) begin
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("result", 96'(bus.result), 96'(r.result));
          check("busy_len", 96'(busy_cnt), 96'(r.base + op_waits));
        end
        busy_cnt = 0;
        op_waits = 0;
        done_cnt++;
      end
    end
  end

  // Transaction commit: a request completes at the rising edge where ack=1.
  always @(posedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ack) begin
      pending = 1'b0;
      if (exp_acc.size() == 0) begin
        fail_now("unexpected_req");
      end else begin
        acc_t e;
        e = exp_acc.pop_front();
        check("acc_we", 96'(bus.mem_we), 96'(e.we));
        check("acc_addr", 96'(bus.mem_addr), 96'(e.addr));
        if (e.we) check("acc_wdata", 96'(bus.mem_wdata), 96'(e.data));
      end
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: expected transactions and responses from the op rules
  // ---------------------------------------------------------------------------
  task automatic model_matmul(input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [AW-1:0] c);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] sum;
        sum = '0;
        for (int k = 0; k < N; k++) begin
          logic [AW-1:0] aa, ba;
          aa = a + AW'(4 * (i * N + k));
          ba = b + AW'(4 * (k * N + j));
          exp_acc.push_back('{1'b0, aa, '0});
          exp_acc.push_back('{1'b0, ba, '0});
          sum = sum + mem_rd(aa) * mem_rd(ba);
        end
        exp_acc.push_back('{1'b1, c + AW'(4 * (i * N + j)), sum});
      end
    end
    exp_rsp.push_back('{DW'(N * N), N * N * (2 * N + 1) + 1});
  endtask

  task automatic model_relu(input logic [AW-1:0] a, input logic [AW-1:0] c);
    int clamp;
    clamp = 0;
    for (int e = 0; e < N * N; e++) begin
      int signed x;
      x = int'(mem_rd(a + AW'(4 * e)));
      exp_acc.push_back('{1'b0, a + AW'(4 * e), '0});
      exp_acc.push_back('{1'b1, c + AW'(4 * e), (x < 0) ? DW'(0) : DW'(x)});
      if (x < 0) clamp++;
    end
    exp_rsp.push_back('{DW'(clamp), 2 * N * N + 1});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] c);
    @(negedge clk);
    #1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.base_a = a;
    bus.base_b = b;
    bus.base_c = c;
    @(negedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // poke=1: pulse start while busy and again in the done cycle; both must
  // be ignored.
  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [AW-1:0] c,
                        input bit poke);
    bit seen;
    case (op)
      2'b00:   model_matmul(a, b, c);
      2'b01:   model_relu(a, c);
      default: exp_rsp.push_back('{DW'(0), 1});
    endcase
    issue(op, a, b, c);
    seen = (bus.done === 1'b1);
    if (poke && !seen) begin
      @(negedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 2'b01;
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      seen = (bus.done === 1'b1);
    end
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      fail_now("done_timeout");
    end else if (poke) begin
      bus.start = 1'b1;
      bus.op    = 2'b00;
    end
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    check("idle_after_done", 96'(bus.busy), 96'(0));
    check("acc_drained", 96'(exp_acc.size()), 96'(0));
  endtask

  task automatic load_a_b_std();
    mem[32'h100] = 32'd1; mem[32'h104] = 32'd2; mem[32'h108] = 32'd3; mem[32'h10C] = 32'd4;
    mem[32'h200] = 32'd5; mem[32'h204] = 32'd6; mem[32'h208] = 32'd7; mem[32'h20C] = 32'd8;
  endtask

  task automatic clear_c();
    for (int e = 0; e < N * N; e++) mem[32'h300 + 32'(4 * e)] = 32'hDEAD_BEEF;
  endtask

  task automatic check_c_std(input string tag);
    check({tag, "_c00"}, 96'(mem_rd(32'h300)), 96'(19));
    check({tag, "_c01"}, 96'(mem_rd(32'h304)), 96'(22));
    check({tag, "_c10"}, 96'(mem_rd(32'h308)), 96'(43));
    check({tag, "_c11"}, 96'(mem_rd(32'h30C)), 96'(50));
  endtask

  task automatic relu_std(input string tag);
    mem[32'h400] = -32'sd3;
    mem[32'h404] = 32'd5;
    mem[32'h408] = 32'd0;
    mem[32'h40C] = 32'h8000_0000;
    for (int e = 0; e < N * N; e++) mem[32'h500 + 32'(4 * e)] = 32'h1234_5678;
    run_op(2'b01, 32'h400, 32'h0, 32'h500, 1'b0);
    check({tag, "_y0"}, 96'(mem_rd(32'h500)), 96'(0));
    check({tag, "_y1"}, 96'(mem_rd(32'h504)), 96'(5));
    check({tag, "_y2"}, 96'(mem_rd(32'h508)), 96'(0));
    check({tag, "_y3"}, 96'(mem_rd(32'h50C)), 96'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int d0;
    bit found;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.base_a    = '0;
    bus.base_b    = '0;
    bus.base_c    = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy",    96'(bus.busy),      96'(0));
    check("rst_done",    96'(bus.done),      96'(0));
    check("rst_req",     96'(bus.mem_req),   96'(0));
    check("rst_we",      96'(bus.mem_we),    96'(0));
    check("rst_addr",    96'(bus.mem_addr),  96'(0));
    check("rst_wdata",   96'(bus.mem_wdata), 96'(0));
    check("rst_result",  96'(bus.result),    96'(0));
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Matmul with always-ack memory, plus ignored start pulses.
    load_a_b_std();
    clear_c();
    max_wait = 0;
    run_op(2'b00, 32'h100, 32'h200, 32'h300, 1'b1);
    check_c_std("mm0");

    // ReLU with always-ack memory.
    relu_std("relu0");

    // Illegal ops.
    run_op(2'b10, 32'h100, 32'h200, 32'h600, 1'b0);
    run_op(2'b11, 32'h100, 32'h200, 32'h600, 1'b0);

    // Overflow: C[0][0] wraps to 0xFFFFFFFF.
    mem[32'h700] = 32'h7FFF_FFFF; mem[32'h704] = 32'd1; mem[32'h708] = 32'd0; mem[32'h70C] = 32'd0;
    mem[32'h800] = 32'd2; mem[32'h804] = 32'd0; mem[32'h808] = 32'd1; mem[32'h80C] = 32'd0;
    run_op(2'b00, 32'h700, 32'h800, 32'h900, 1'b0);
    check("ovf_c00", 96'(mem_rd(32'h900)), 96'(32'hFFFF_FFFF));

    // Same scenarios with random 0-3 wait states.
    max_wait = 3;
    clear_c();
    run_op(2'b00, 32'h100, 32'h200, 32'h300, 1'b1);
    check_c_std("mmw");
    relu_std("reluw");

    // Random matrices and vectors with wait states.
    for (int it = 0; it < 4; it++) begin
      for (int e = 0; e < N * N; e++) begin
        mem[32'h1000 + 32'(4 * e)] = $urandom;
        mem[32'h2000 + 32'(4 * e)] = $urandom;
      end
      run_op(2'b00, 32'h1000, 32'h2000, 32'h3000, 1'b0);
      run_op(2'b01, 32'h1000, 32'h0, 32'h4000, 1'b0);
    end

    // Reset during the first WR_C while the write request is pending.
    max_wait = 0;
    clear_c();
    model_matmul(32'h100, 32'h200, 32'h300);
    issue(2'b00, 32'h100, 32'h200, 32'h300);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      #1;
      if (bus.mem_req && bus.mem_we) found = 1'b1;
    end
    if (!found) fail_now("wr_c_timeout");
    rst = 1'b1;
    #1;
    check("rstmid_req",  96'(bus.mem_req), 96'(0));
    check("rstmid_busy", 96'(bus.busy),    96'(0));
    exp_acc.delete();
    exp_rsp.delete();
    pending  = 1'b0;
    busy_cnt = 0;
    op_waits = 0;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_no_done", 96'(done_cnt), 96'(d0));
    check("rstmid_c00_untouched", 96'(mem_rd(32'h300)), 96'(32'hDEAD_BEEF));

    // Fresh start after the abandoned op completes normally.
    run_op(2'b00, 32'h100, 32'h200, 32'h300, 1'b0);
    check_c_std("mm_after_rst");

    repeat (3) @(negedge clk);
    check("final_rsp_drained", 96'(exp_rsp.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/custom_seq.md
Name: custom_seq

Overview:
- Multi-cycle sequencer for the custom-0 opcode instructions: matrix multiply (funct3 000) and ReLU (funct3 001).
- Control-unit decode raises `start` with the op code; this block stalls the core via `busy` and runs the operation over an NxN int32 matrix in data memory.
- It returns a scalar result for rd and pulses `done`.
- It owns the data-memory port while busy, using a single-outstanding req/ack handshake.

Parameters:
- N, 2, matrix dimension (N>=1); element index range 0..N*N-1
- AW, 32, memory address width
- DW, 32, element / data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue pulse (custom_en & instruction valid); sampled only in IDLE
- op  in  2  00 = matmul, 01 = ReLU, 10/11 = illegal
- base_a  in  AW  rs1 value: matrix A (matmul) or input X (ReLU), row-major, 4-byte elements
- base_b  in  AW  rs2 value: matrix B (matmul only)
- base_c  in  AW  destination base (C or Y), from config register
- busy  out  1  pipeline stall request
- done  out  1  one-cycle completion pulse
- result  out  DW  rd write value; valid while done=1
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  byte address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data; valid when mem_ack=1
- mem_ack  in  1  transaction complete; may assert in the same cycle as mem_req

Behaviour:
- **Reset:**
  - State IDLE.
  - busy, done, mem_req, mem_we = 0.
  - result, mem_addr, mem_wdata, acc, a_reg, i, j, k, e, clamp count = 0.
  - Reset mid-operation abandons the op immediately: mem_req drops asynchronously and no done pulse is produced.
- **Start capture:** start is captured in IDLE only. base_a/b/c and op are latched at the accepting edge. start while busy is ignored.
- **busy:** high from the cycle after acceptance through the DONE cycle inclusive.
- **Memory handshake:**
  - Once mem_req is raised, mem_we/mem_addr/mem_wdata stay stable until the edge where mem_ack=1.
  - mem_req deasserts, or moves to the next request, the cycle after ack.
  - There is one outstanding request only. mem_ack without mem_req is ignored.
- **States:** IDLE, RD_A, RD_B, WR_C, RD_X, WR_Y, DONE.
  - IDLE -> RD_A (op=00, i=j=k=0, acc=0).
  - IDLE -> RD_X (op=01, e=0, clamp=0).
  - IDLE -> DONE (op illegal; no memory access, result=0).
- **Matmul:**
  - RD_A reads base_a + 4*(i*N+k). On ack: a_reg <= rdata, go to RD_B.
  - RD_B reads base_b + 4*(k*N+j). On ack: acc <= acc + low DW bits of (a_reg*rdata), wrapping mod 2^DW (sign-agnostic). Then k<N-1 -> k++, RD_A; else -> WR_C.
  - WR_C writes acc to base_c + 4*(i*N+j). On ack: acc=0, k=0, advance j then i (row-major). After i=j=N-1 -> DONE.
  - result = N*N.
- **ReLU:**
  - RD_X reads base_a + 4*e. On ack: latch value, go to WR_Y.
  - WR_Y writes the signed value, or 0 if negative, to base_c + 4*e. Negative values count into clamp.
  - On ack: e<N*N-1 -> e++, RD_X; else -> DONE.
  - result = clamp count.
- **DONE:** done=1 for exactly one cycle, result valid, then -> IDLE with busy=0 the next cycle.
- **Address arithmetic:** mod 2^AW; wrap-around is not flagged.
- **Latency** (always-ack memory, start accepted at edge 0):
  - Matmul: busy for N*N*(2N+1)+1 cycles (N=2: 21).
  - ReLU: 2*N*N+1 cycles (N=2: 9).
  - Illegal op: 1 cycle.
  - Each wait cycle adds exactly one cycle.
- **Back-to-back:** a start in the cycle done=1 is ignored; the next start is accepted once in IDLE.

Test Plan:
- **Matmul, always-ack memory, N=2:** A=[1,2;3,4] @0x100, B=[5,6;7,8] @0x200, base_c=0x300.
  - 0x300..0x30C = 19, 22, 43, 50.
  - busy for 21 cycles, done 1 cycle, result=4.
  - Access order: reads 0x100, 0x200, 0x104, 0x208, then write 0x300.
- **ReLU, N=2:** X=[-3,5,0,-2147483648] @0x400, base_c=0x500.
  - Y=[0,5,0,0], result=2, busy 9 cycles.
- **Random 0-3 wait-state ack:**
  - Same results as the first two scenarios.
  - mem_addr/we/wdata never change while req=1 and ack=0.
  - busy length = base + total waits.
- **Overflow:** A=[0x7FFFFFFF,1;0,0], B=[2,0;1,0].
  - C[0][0] = 0xFFFFFFFF (wrapped), no error.
- **Illegal op=10:** done at cycle 1, result=0, mem_req never asserted. start pulses while busy in the first scenario have no effect.
- **Reset mid-matmul:** rst asserted during WR_C while mem_req=1.
  - mem_req=0 and busy=0 immediately.
  - No done pulse.
  - A subsequent start completes the first scenario correctly.
